// File: rtl/id_scoreboard_pkg.sv
// Shared constants for the decode-stage register scoreboard: register-file ids,
// the latency codes the control unit drives onto issue_lat_i, and a width helper.
package id_scoreboard_pkg;

   localparam int SB_LAT_WIDTH = 4;

   localparam int RF_INT = 0;
   localparam int RF_FP  = 1;

   localparam int LAT_LOAD = 1;
   localparam int LAT_MUL  = 2;
   localparam int LAT_FPU  = 3;
   localparam int LAT_DIV  = 15;

   // A single register file still needs a 1-bit select field.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// Issue/writeback/stall bundle between the decode stage (master) and the
// register scoreboard (slave).
interface id_scoreboard_if #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NUM_RF         = 2,
   parameter int NUM_SRC        = 3,
   parameter int LAT_WIDTH      = 4
);
   localparam int RF_W  = id_scoreboard_pkg::clog2_min1(NUM_RF);
   localparam int CNT_W = $clog2(NUM_RF * (2 ** REG_ADDR_WIDTH)) + 1;

   logic                              issue_valid_i;
   logic                              issue_wr_i;
   logic [RF_W-1:0]                   issue_rf_i;
   logic [REG_ADDR_WIDTH-1:0]         issue_waddr_i;
   logic [LAT_WIDTH-1:0]              issue_lat_i;
   logic [NUM_SRC-1:0]                issue_src_en_i;
   logic [NUM_SRC*RF_W-1:0]           issue_src_rf_i;
   logic [NUM_SRC*REG_ADDR_WIDTH-1:0] issue_src_addr_i;
   logic                              flush_i;
   logic                              wb_valid_i;
   logic [RF_W-1:0]                   wb_rf_i;
   logic [REG_ADDR_WIDTH-1:0]         wb_waddr_i;
   logic                              stall_o;
   logic                              issue_accept_o;
   logic [NUM_SRC-1:0]                src_pending_o;
   logic                              busy_o;
   logic [CNT_W-1:0]                  pending_cnt_o;

   modport master (
      output issue_valid_i, issue_wr_i, issue_rf_i, issue_waddr_i, issue_lat_i,
             issue_src_en_i, issue_src_rf_i, issue_src_addr_i, flush_i,
             wb_valid_i, wb_rf_i, wb_waddr_i,
      input  stall_o, issue_accept_o, src_pending_o, busy_o, pending_cnt_o
   );

   modport slave (
      input  issue_valid_i, issue_wr_i, issue_rf_i, issue_waddr_i, issue_lat_i,
             issue_src_en_i, issue_src_rf_i, issue_src_addr_i, flush_i,
             wb_valid_i, wb_rf_i, wb_waddr_i,
      output stall_o, issue_accept_o, src_pending_o, busy_o, pending_cnt_o
   );

endinterface

// File: rtl/id_scoreboard_sb_entry.sv
// One scoreboard entry: pending bit plus a saturating latency countdown.
// Set beats clear so an accept overrides a same-cycle writeback.
module sb_entry #(
   parameter int LAT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 set_i,
   input  logic [LAT_WIDTH-1:0] lat_i,
   input  logic                 clr_i,
   output logic                 pend_o,
   output logic                 busy_o
);

   logic                 pend_q, pend_d;
   logic [LAT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      pend_d = pend_q;
      cnt_d  = (cnt_q != '0) ? cnt_q - LAT_WIDTH'(1) : cnt_q;
      if (set_i) begin
         pend_d = 1'b1;
         cnt_d  = lat_i;
      end else if (clr_i) begin
         pend_d = 1'b0;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pend_o = pend_q;
   assign busy_o = pend_q & (cnt_q != '0);

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: per-register in-flight tracking for the
// integer and float files, RAW/WAW stall generation and a pending-entry count.
module id_scoreboard
   import id_scoreboard_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NUM_RF         = 2,
   parameter int NUM_SRC        = 3,
   parameter int LAT_WIDTH      = 4
) (
   input  logic           clk,
   input  logic           rst,
   id_scoreboard_if.slave sb
);

   localparam int RF_W    = clog2_min1(NUM_RF);
   localparam int IDX_W   = RF_W + REG_ADDR_WIDTH;
   localparam int NUM_ENT = NUM_RF * (2 ** REG_ADDR_WIDTH);
   localparam int CNT_W   = $clog2(NUM_ENT) + 1;

   logic [(2**IDX_W)-1:0] pend_vec;
   logic [(2**IDX_W)-1:0] busy_vec;
   logic [IDX_W-1:0]      dst_idx;
   logic [IDX_W-1:0]      wb_idx;
   logic [IDX_W-1:0]      src_idx [NUM_SRC];
   logic                  raw, waw, stall, accept, set_en, wb_dec;
   logic [NUM_SRC-1:0]    src_pend;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  busy_q, busy_d;

   // Entry index is {file, register}, so entry 0 is integer x0.
   assign dst_idx = {sb.issue_rf_i, sb.issue_waddr_i};
   assign wb_idx  = {sb.wb_rf_i, sb.wb_waddr_i};

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      assign src_idx[k] = {sb.issue_src_rf_i[k*RF_W +: RF_W],
                           sb.issue_src_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]};
   end

   for (genvar i = 0; i < 2**IDX_W; i++) begin : g_ent
      if (i < NUM_ENT) begin : g_real
         sb_entry #(.LAT_WIDTH(LAT_WIDTH)) u_entry (
            .clk    (clk),
            .rst    (rst),
            .set_i  (set_en && (dst_idx == IDX_W'(i))),
            .lat_i  (sb.issue_lat_i),
            .clr_i  (sb.wb_valid_i && (wb_idx == IDX_W'(i))),
            .pend_o (pend_vec[i]),
            .busy_o (busy_vec[i])
         );
      end else begin : g_pad
         assign pend_vec[i] = 1'b0;
         assign busy_vec[i] = 1'b0;
      end
   end

   always_comb begin
      raw      = 1'b0;
      src_pend = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         src_pend[k] = pend_vec[src_idx[k]];
         if (sb.issue_src_en_i[k] && busy_vec[src_idx[k]]) raw = 1'b1;
      end
      waw    = sb.issue_wr_i && busy_vec[dst_idx];
      stall  = sb.issue_valid_i && (raw || waw);
      accept = sb.issue_valid_i && !stall && !sb.flush_i;
      set_en = accept && sb.issue_wr_i && (dst_idx != '0);
   end

   // Count tracks the pending bits; a writeback overridden by an accept is net 0.
   always_comb begin
      wb_dec = sb.wb_valid_i && pend_vec[wb_idx] && !(set_en && (dst_idx == wb_idx));
      cnt_d  = cnt_q;
      if (set_en && !pend_vec[dst_idx]) cnt_d = cnt_d + CNT_W'(1);
      if (wb_dec) cnt_d = cnt_d - CNT_W'(1);
      busy_d = (cnt_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign sb.stall_o        = stall;
   assign sb.issue_accept_o = accept;
   assign sb.src_pending_o  = src_pend;
   assign sb.busy_o         = busy_q;
   assign sb.pending_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed per-cycle vector table, then random traffic,
// both checked against a ready-time model of the register scoreboard.
module tb_id_scoreboard;
   import id_scoreboard_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_scoreboard_if sb_if ();

   id_scoreboard dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if.slave)
   );

   // Model: an entry is forwardable once the cycle count reaches its ready time.
   bit      m_pend  [2][32];
   longint  m_ready [2][32];
   longint  cyc = 0;
   bit      m_acc;
   int      n_cmp = 0;
   int      n_bad = 0;

   typedef struct {
      bit rst, valid, wr;
      int rf, wa, lat;
      int en, srf, sa;
      bit flush, wbv;
      int wbrf, wba;
      bit e_stall, e_acc, e_sp0;
      int e_cnt;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit r, input bit v, input bit w, input int rf, input int wa,
                      input int lat, input int en, input int srf, input int sa,
                      input bit fl, input bit wbv, input int wbrf, input int wba,
                      input bit es, input bit ea, input bit ep, input int ec);
      vec_t t;
      t.rst = r; t.valid = v; t.wr = w; t.rf = rf; t.wa = wa; t.lat = lat;
      t.en = en; t.srf = srf; t.sa = sa; t.flush = fl; t.wbv = wbv;
      t.wbrf = wbrf; t.wba = wba; t.e_stall = es; t.e_acc = ea; t.e_sp0 = ep; t.e_cnt = ec;
      tbl.push_back(t);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit m_busy(input int f, input int a);
      return m_pend[f][a] && (cyc < m_ready[f][a]);
   endfunction

   task automatic drive(input bit r, input bit v, input bit w, input int rf, input int wa,
                        input int lat, input int en, input int s0rf, input int s0a,
                        input int s1rf, input int s1a, input int s2rf, input int s2a,
                        input bit fl, input bit wbv, input int wbrf, input int wba);
      rst                    = r;
      sb_if.issue_valid_i    = v;
      sb_if.issue_wr_i       = w;
      sb_if.issue_rf_i       = 1'(rf);
      sb_if.issue_waddr_i    = 5'(wa);
      sb_if.issue_lat_i      = 4'(lat);
      sb_if.issue_src_en_i   = 3'(en);
      sb_if.issue_src_rf_i   = {1'(s2rf), 1'(s1rf), 1'(s0rf)};
      sb_if.issue_src_addr_i = {5'(s2a), 5'(s1a), 5'(s0a)};
      sb_if.flush_i          = fl;
      sb_if.wb_valid_i       = wbv;
      sb_if.wb_rf_i          = 1'(wbrf);
      sb_if.wb_waddr_i       = 5'(wba);
   endtask

   task automatic model_check();
      bit raw, waw, stall;
      int f, a, cnt;
      logic [2:0] sp;
      raw = 0;
      sp  = '0;
      for (int k = 0; k < 3; k++) begin
         f = int'(sb_if.issue_src_rf_i[k]);
         a = int'(sb_if.issue_src_addr_i[k*5 +: 5]);
         sp[k] = m_pend[f][a];
         if (sb_if.issue_src_en_i[k] && m_busy(f, a)) raw = 1;
      end
      waw   = sb_if.issue_wr_i && m_busy(int'(sb_if.issue_rf_i), int'(sb_if.issue_waddr_i));
      stall = sb_if.issue_valid_i && (raw || waw);
      m_acc = sb_if.issue_valid_i && !stall && !sb_if.flush_i;
      cnt = 0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 32; j++)
            cnt += int'(m_pend[i][j]);
      chk("model_stall", int'(sb_if.stall_o), int'(stall));
      chk("model_accept", int'(sb_if.issue_accept_o), int'(m_acc));
      chk("model_src_pending", int'(sb_if.src_pending_o), int'(sp));
      chk("model_pending_cnt", int'(sb_if.pending_cnt_o), cnt);
      chk("model_busy", int'(sb_if.busy_o), int'(cnt != 0));
   endtask

   task automatic model_step();
      int f, a;
      if (rst) begin
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 32; j++) begin
               m_pend[i][j]  = 0;
               m_ready[i][j] = 0;
            end
      end else begin
         if (sb_if.wb_valid_i) m_pend[int'(sb_if.wb_rf_i)][int'(sb_if.wb_waddr_i)] = 0;
         f = int'(sb_if.issue_rf_i);
         a = int'(sb_if.issue_waddr_i);
         if (m_acc && sb_if.issue_wr_i && !(f == RF_INT && a == 0)) begin
            m_pend[f][a]  = 1;
            m_ready[f][a] = cyc + 1 + longint'(sb_if.issue_lat_i);
         end
      end
      cyc++;
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      // x5 lat 3, dependent consumer, then writeback
      add(0,1,1,0,5,3, 0,0,0, 0,0,0,0, 0,1,0,0);
      add(0,1,0,0,0,0, 1,0,5, 0,0,0,0, 1,0,1,1);
      add(0,1,0,0,0,0, 1,0,5, 0,0,0,0, 1,0,1,1);
      add(0,1,0,0,0,0, 1,0,5, 0,0,0,0, 1,0,1,1);
      add(0,1,0,0,0,0, 1,0,5, 0,0,0,0, 0,1,1,1);
      add(0,0,0,0,0,0, 1,0,5, 0,1,0,5, 0,0,1,1);
      add(0,0,0,0,0,0, 1,0,5, 0,0,0,0, 0,0,0,0);
      // x0 is never tracked
      add(0,1,1,0,0,7, 0,0,0, 0,0,0,0, 0,1,0,0);
      add(0,1,0,0,0,0, 1,0,0, 0,0,0,0, 0,1,0,0);
      add(0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0);
      // f5 vs x5 are distinct entries
      add(0,1,1,1,5,2, 0,0,0, 0,0,0,0, 0,1,0,0);
      add(0,1,0,0,0,0, 1,0,5, 0,0,0,0, 0,1,0,1);
      add(0,1,0,0,0,0, 1,1,5, 0,0,0,0, 1,0,1,1);
      add(0,1,0,0,0,0, 1,1,5, 0,0,0,0, 0,1,1,1);
      add(0,0,0,0,0,0, 0,0,0, 0,1,1,5, 0,0,0,1);
      // WAW on x8, then accept-over-writeback
      add(0,1,1,0,8,4, 0,0,0, 0,0,0,0, 0,1,0,0);
      add(0,1,1,0,8,0, 0,0,0, 0,0,0,0, 1,0,0,1);
      add(0,1,1,0,8,0, 0,0,0, 0,0,0,0, 1,0,0,1);
      add(0,1,1,0,8,0, 0,0,0, 0,0,0,0, 1,0,0,1);
      add(0,1,1,0,8,0, 0,0,0, 0,0,0,0, 1,0,0,1);
      add(0,1,1,0,8,0, 0,0,0, 0,1,0,8, 0,1,0,1);
      add(0,0,0,0,0,0, 1,0,8, 0,0,0,0, 0,0,1,1);
      add(0,0,0,0,0,0, 0,0,0, 0,1,0,8, 0,0,0,1);
      add(0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0);
      // flush suppresses the x9 writer for one cycle only
      add(0,1,1,0,9,3, 0,0,0, 1,0,0,0, 0,0,0,0);
      add(0,1,1,0,9,3, 0,0,9, 0,0,0,0, 0,1,0,0);
      add(0,1,0,0,0,0, 1,0,9, 0,0,0,0, 1,0,1,1);
      // three pending, then reset mid-flight with an ignored writeback
      add(0,1,1,1,3,5, 0,0,0, 0,0,0,0, 0,1,0,1);
      add(0,1,1,0,12,6, 0,0,0, 0,0,0,0, 0,1,0,2);
      add(0,1,0,0,0,0, 1,0,12, 0,0,0,0, 1,0,1,3);
      add(1,1,0,0,0,0, 1,0,12, 0,1,0,9, 1,0,1,3);
      add(0,1,0,0,0,0, 1,0,12, 0,0,0,0, 0,1,0,0);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].valid, tbl[i].wr, tbl[i].rf, tbl[i].wa, tbl[i].lat,
               tbl[i].en, tbl[i].srf, tbl[i].sa, 0, 0, 0, 0,
               tbl[i].flush, tbl[i].wbv, tbl[i].wbrf, tbl[i].wba);
         @(negedge clk);
         chk($sformatf("vec%0d_stall", i), int'(sb_if.stall_o), int'(tbl[i].e_stall));
         chk($sformatf("vec%0d_accept", i), int'(sb_if.issue_accept_o), int'(tbl[i].e_acc));
         chk($sformatf("vec%0d_src_pending0", i), int'(sb_if.src_pending_o[0]), int'(tbl[i].e_sp0));
         chk($sformatf("vec%0d_pending_cnt", i), int'(sb_if.pending_cnt_o), tbl[i].e_cnt);
         chk($sformatf("vec%0d_busy", i), int'(sb_if.busy_o), int'(tbl[i].e_cnt != 0));
         model_check();
         @(posedge clk);
         model_step();
         #1;
      end

      // Random traffic on a narrow register window to force collisions.
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 149) == 0),
               ($urandom_range(0, 9) < 7),
               1'($urandom),
               $urandom_range(0, 1), $urandom_range(0, 3),
               ($urandom_range(0, 15) == 0) ? LAT_DIV : $urandom_range(0, 5),
               $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 9) < 4),
               $urandom_range(0, 1), $urandom_range(0, 3));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
